// File: rtl/fix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fix_pkg                                                      |
// | Description : Shared types and byte/tag constants for the FIX tokenizer.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fix_pkg;

    typedef enum logic [1:0] {
        S_TAG   = 2'd0,
        S_VALUE = 2'd1,
        S_SKIP  = 2'd2
    } tok_state_e;

    localparam logic [7:0] SOH      = 8'h01;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;

    localparam int unsigned TAG_BEGIN_STRING = 8;
    localparam int unsigned TAG_CHECKSUM     = 10;

endpackage
`default_nettype wire

// File: rtl/fix_dec_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fix_dec_accum                                                |
// | Description : ASCII-decimal accumulator with digit count and full flag.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fix_dec_accum #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_DIGITS = 9,
    parameter int unsigned NDIG_W     = $clog2(MAX_DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [7:0]            i_char,
    output logic [DATA_WIDTH-1:0] o_value,
    output logic [NDIG_W-1:0]     o_ndig,
    output logic                  o_full
);
    import fix_pkg::*;

    logic [DATA_WIDTH-1:0] r_acc;
    logic [NDIG_W-1:0]     r_ndig;
    logic [DATA_WIDTH+3:0] w_next;

    // Widened product, then truncated back to the tag width.
    assign w_next = ({4'b0, r_acc} * (DATA_WIDTH+4)'(10))
                  + (DATA_WIDTH+4)'(i_char - ASCII_0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_ndig <= '0;
        end else if (i_clr) begin
            r_acc  <= '0;
            r_ndig <= '0;
        end else if (i_en) begin
            r_acc  <= w_next[DATA_WIDTH-1:0];
            r_ndig <= r_ndig + NDIG_W'(1);
        end
    end

    assign o_value = r_acc;
    assign o_ndig  = r_ndig;
    assign o_full  = (r_ndig == NDIG_W'(MAX_DIGITS));

endmodule
`default_nettype wire

// File: rtl/fix_tag_tokenizer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fix_tag_tokenizer                                            |
// | Description : Parses FIX tag=value fields, writes tags to the CAM and      |
// |               frames messages; forwards value bytes on a side stream.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fix_tag_tokenizer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_DIGITS = 9,
    parameter logic [7:0]  SOH        = 8'h01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    input  logic                  cam_full_i,
    output logic                  wr_cs_o,
    output logic                  wr_en_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  start_message_o,
    output logic                  end_message_o,
    output logic [7:0]            value_byte_o,
    output logic                  value_valid_o,
    output logic                  value_last_o,
    output logic                  err_o,
    output logic [7:0]            field_cnt_o
);
    import fix_pkg::*;

    localparam int unsigned NDIG_W = $clog2(MAX_DIGITS + 1);

    tok_state_e            r_state;
    logic                  r_in_msg;
    logic                  r_is_cksum;
    logic                  r_have_val;
    logic [7:0]            r_last_val;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_start;
    logic                  r_end;
    logic                  r_err;
    logic [7:0]            r_vbyte;
    logic                  r_vvalid;
    logic                  r_vlast;
    logic [7:0]            r_field_cnt;

    logic [DATA_WIDTH-1:0] w_acc_val;
    logic [NDIG_W-1:0]     w_ndig;
    logic                  w_acc_full;
    logic                  w_accept;
    logic                  w_tag;
    logic                  w_is_digit;
    logic                  w_eq_ok;
    logic                  w_is_begin;
    logic                  w_digit_en;
    logic                  w_acc_clr;
    logic                  w_write;
    logic                  w_err;

    assign byte_ready_o = ~cam_full_i;
    assign w_accept     = byte_valid_i & ~cam_full_i;
    assign w_tag        = w_accept && (r_state == S_TAG);
    assign w_is_digit   = (byte_i >= ASCII_0) && (byte_i <= ASCII_9);
    assign w_eq_ok      = (byte_i == ASCII_EQ) && (w_ndig != '0);
    assign w_is_begin   = (w_acc_val == DATA_WIDTH'(TAG_BEGIN_STRING));
    assign w_digit_en   = w_tag && w_is_digit && !w_acc_full;
    assign w_acc_clr    = w_tag && !w_digit_en;
    // Outside a message only BeginString may open a field; anything else in S_TAG that is neither a digit nor a write is an error.
    assign w_write      = w_tag && w_eq_ok && (r_in_msg || w_is_begin);
    assign w_err        = w_tag && !w_digit_en && !w_write;

    fix_dec_accum #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_DIGITS (MAX_DIGITS),
        .NDIG_W     (NDIG_W)
    ) u_accum (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_acc_clr),
        .i_en    (w_digit_en),
        .i_char  (byte_i),
        .o_value (w_acc_val),
        .o_ndig  (w_ndig),
        .o_full  (w_acc_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_TAG;
            r_in_msg    <= 1'b0;
            r_is_cksum  <= 1'b0;
            r_have_val  <= 1'b0;
            r_last_val  <= '0;
            r_wr        <= 1'b0;
            r_data      <= '0;
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_err       <= 1'b0;
            r_vbyte     <= '0;
            r_vvalid    <= 1'b0;
            r_vlast     <= 1'b0;
            r_field_cnt <= '0;
        end else begin
            r_wr     <= w_write;
            r_data   <= w_write ? w_acc_val : '0;
            r_start  <= w_write && w_is_begin;
            // A BeginString inside an open message restarts it and is flagged.
            r_err    <= w_err || (w_write && w_is_begin && r_in_msg);
            r_end    <= 1'b0;
            r_vvalid <= 1'b0;
            r_vlast  <= 1'b0;
            if (w_err) begin
                r_in_msg   <= 1'b0;
                r_is_cksum <= 1'b0;
                r_have_val <= 1'b0;
                r_state    <= S_SKIP;
            end else if (w_write) begin
                r_state <= S_VALUE;
                if (w_is_begin) begin
                    r_in_msg    <= 1'b1;
                    r_is_cksum  <= 1'b0;
                    r_field_cnt <= '0;
                end else if (w_acc_val == DATA_WIDTH'(TAG_CHECKSUM)) begin
                    r_is_cksum <= 1'b1;
                end
            end else if (w_accept) begin
                case (r_state)
                    S_VALUE: begin
                        if (byte_i != SOH) begin
                            r_vvalid   <= r_have_val;
                            if (r_have_val)
                                r_vbyte <= r_last_val;
                            r_last_val <= byte_i;
                            r_have_val <= 1'b1;
                        end else begin
                            r_vvalid   <= 1'b1;
                            r_vlast    <= 1'b1;
                            r_vbyte    <= r_have_val ? r_last_val : SOH;
                            r_have_val <= 1'b0;
                            r_state    <= S_TAG;
                            if (r_field_cnt != 8'hFF)
                                r_field_cnt <= r_field_cnt + 8'd1;
                            if (r_is_cksum) begin
                                r_end      <= 1'b1;
                                r_in_msg   <= 1'b0;
                                r_is_cksum <= 1'b0;
                            end
                        end
                    end
                    S_SKIP: begin
                        if (byte_i == SOH)
                            r_state <= S_TAG;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wr_cs_o         = r_wr;
    assign wr_en_o         = r_wr;
    assign data_o          = r_data;
    assign start_message_o = r_start;
    assign end_message_o   = r_end;
    assign err_o           = r_err;
    assign value_byte_o    = r_vbyte;
    assign value_valid_o   = r_vvalid;
    assign value_last_o    = r_vlast;
    assign field_cnt_o     = r_field_cnt;

endmodule
`default_nettype wire
